// File: rtl/laserdrop_pkg.sv
// Shared types and constants for the FTDI-to-laser frame receive path.
package laserdrop_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned MAX_FRAME_LEN = 255;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rdq_fetch.sv
// Drains a non-show-ahead read queue one byte at a time into a single hold slot.
module rdq_fetch (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       rdq_empty,
  input  logic [7:0] data_rd,
  input  logic       consume,
  output logic       rdreq,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid
);

  logic       inflight;
  logic       hold_valid;
  logic [7:0] hold;

  assign rdreq = reset_n && !rdq_empty && !inflight && !hold_valid && !clear;

  // The in-flight byte is offered straight from data_rd; it only lands in the
  // hold register if nobody takes it that cycle, giving one byte per 2 cycles.
  assign rx_byte_valid = hold_valid || inflight;
  assign rx_byte       = hold_valid ? hold : data_rd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight   <= 1'b0;
      hold_valid <= 1'b0;
      hold       <= '0;
    end else if (clear) begin
      inflight   <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      inflight <= rdreq;
      if (inflight && !consume) begin
        hold       <= data_rd;
        hold_valid <= 1'b1;
      end else if (consume) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ftdi_frame_rx.sv
// Sync-hunting, length-prefixed frame parser with XOR checksum, feeding the
// laser transmit path over a valid/ready stream.
module ftdi_frame_rx
  import laserdrop_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        rdq_empty,
  input  logic [7:0]  data_rd,
  output logic        rdreq,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [7:0]  frame_len,
  output logic [15:0] frame_count,
  output logic [15:0] err_count,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LW = $clog2(MAX_FRAME_LEN + 1);

  rx_state_t     state;
  logic [7:0]    rx_byte;
  logic          rx_byte_valid;
  logic          consume;
  logic          waiting;
  logic          timed_out;
  logic [LW-1:0] len_r;
  logic [LW-1:0] remaining;
  logic [7:0]    chk;
  logic [TW-1:0] tcnt;

  rdq_fetch u_fetch (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear         (clear),
    .rdq_empty     (rdq_empty),
    .data_rd       (data_rd),
    .consume       (consume),
    .rdreq         (rdreq),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid)
  );

  assign busy      = (state != HUNT);
  assign out_valid = (state == PAYLOAD) && rx_byte_valid;
  assign out_data  = out_valid ? rx_byte : '0;
  assign out_sop   = out_valid && (remaining == len_r);
  assign out_eop   = out_valid && (remaining == LW'(1));
  assign consume   = !clear && rx_byte_valid && ((state != PAYLOAD) || out_ready);

  // Only starvation counts toward the timeout; a held byte stalled by the
  // consumer is not waiting on the queue.
  assign waiting   = busy && rdq_empty && !rx_byte_valid;
  assign timed_out = waiting && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      len_r       <= '0;
      remaining   <= '0;
      chk         <= '0;
      tcnt        <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_len   <= '0;
      frame_count <= '0;
      err_count   <= '0;
    end else if (clear) begin
      state       <= HUNT;
      len_r       <= '0;
      remaining   <= '0;
      chk         <= '0;
      tcnt        <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_len   <= '0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!busy || rdreq) begin
        tcnt <= '0;
      end else if (waiting) begin
        tcnt <= tcnt + 1'b1;
      end

      if (timed_out) begin
        frame_done <= 1'b1;
        frame_ok   <= 1'b0;
        frame_len  <= (state == LEN) ? '0 : len_r;
        err_count  <= sat_inc16(err_count);
        state      <= HUNT;
      end else begin
        case (state)
          HUNT: begin
            if (rx_byte_valid && (rx_byte == SYNC_BYTE)) state <= LEN;
          end
          LEN: begin
            if (rx_byte_valid) begin
              if (rx_byte == '0) begin
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                frame_len  <= '0;
                err_count  <= sat_inc16(err_count);
                state      <= HUNT;
              end else begin
                len_r     <= rx_byte;
                remaining <= rx_byte;
                chk       <= rx_byte;
                state     <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (out_valid && out_ready) begin
              chk       <= chk ^ rx_byte;
              remaining <= remaining - 1'b1;
              if (remaining == LW'(1)) state <= CHK;
            end
          end
          CHK: begin
            if (rx_byte_valid) begin
              frame_done <= 1'b1;
              frame_ok   <= (rx_byte == chk);
              frame_len  <= len_r;
              if (rx_byte == chk) frame_count <= sat_inc16(frame_count);
              else                err_count   <= sat_inc16(err_count);
              state <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
